// File: rtl/bram_dp_ctrl_if.sv
// Port bundle for bram_dp_ctrl: user read/write ports, clear request and status.
// The master side drives requests and write data; the slave side is the controller.
interface bram_dp_ctrl_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 10
);
   logic                  clear_req;
   logic                  we1;
   logic                  we2;
   logic [ADDR_WIDTH-1:0] addr1;
   logic [ADDR_WIDTH-1:0] addr2;
   logic [DATA_WIDTH-1:0] data1;
   logic [DATA_WIDTH-1:0] data2;
   logic [DATA_WIDTH-1:0] out1;
   logic [DATA_WIDTH-1:0] out2;
   logic                  busy;
   logic                  collision;

   modport master (
      output clear_req, we1, we2, addr1, addr2, data1, data2,
      input  out1, out2, busy, collision
   );

   modport slave (
      input  clear_req, we1, we2, addr1, addr2, data1, data2,
      output out1, out2, busy, collision
   );
endinterface

// File: rtl/bram_dp_ctrl.sv
// Dual-port BRAM controller: self-clearing FSM, port-1-wins collision rule, read-first ports.
// Optional output pipeline register enabled by defining BRAM_OUT_REG_EN.
module bram_dp_ctrl #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 10
) (
   input logic             clk,
   input logic             reset,
   bram_dp_ctrl_if.slave   bus
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int HALF  = DEPTH / 2;
   localparam int CNT_W = (ADDR_WIDTH > 1) ? ADDR_WIDTH - 1 : 1;

   typedef enum logic {CLEAR, READY} state_t;

   state_t                state;
   state_t                next_state;
   logic [CNT_W-1:0]      cnt;
   logic                  clearing;
   logic                  last_cnt;
   logic                  hit;
   logic                  port_we1;
   logic                  port_we2;
   logic [ADDR_WIDTH-1:0] port_addr1;
   logic [ADDR_WIDTH-1:0] port_addr2;
   logic [DATA_WIDTH-1:0] port_din1;
   logic [DATA_WIDTH-1:0] port_din2;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] q1;
   logic [DATA_WIDTH-1:0] q2;
   logic [DATA_WIDTH-1:0] masked1;
   logic [DATA_WIDTH-1:0] masked2;
   logic                  coll_q;

   assign clearing = (state == CLEAR);
   assign last_cnt = (cnt == CNT_W'(HALF - 1));
   assign hit      = bus.we1 & bus.we2 & (bus.addr1 == bus.addr2);

   // State and clear counter; the counter rests at zero outside CLEAR so a new clear starts cleanly
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= CLEAR;
         cnt   <= '0;
      end else begin
         state <= next_state;
         if (clearing && !last_cnt) begin
            cnt <= cnt + CNT_W'(1);
         end else begin
            cnt <= '0;
         end
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         CLEAR: if (last_cnt)      next_state = READY;
         READY: if (bus.clear_req) next_state = CLEAR;
      endcase
   end

   // Primitive port muxing: CLEAR sweeps both halves of the array in parallel
   always_comb begin
      port_we1   = bus.we1;
      port_we2   = bus.we2 & ~hit;
      port_addr1 = bus.addr1;
      port_addr2 = bus.addr2;
      port_din1  = bus.data1;
      port_din2  = bus.data2;
      if (clearing) begin
         port_we1   = 1'b1;
         port_we2   = 1'b1;
         port_addr1 = ADDR_WIDTH'(cnt);
         port_addr2 = ADDR_WIDTH'(cnt) + ADDR_WIDTH'(HALF);
         port_din1  = '0;
         port_din2  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         if (port_we1) mem[port_addr1] <= port_din1;
         if (port_we2) mem[port_addr2] <= port_din2;
      end
   end

   // Registered reads see the array before this edge's writes, giving read-first behaviour
   always_ff @(posedge clk) begin
      if (reset || clearing) begin
         q1 <= '0;
         q2 <= '0;
      end else begin
         q1 <= mem[port_addr1];
         q2 <= mem[port_addr2];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         coll_q <= 1'b0;
      end else begin
         coll_q <= ~clearing & hit;
      end
   end

   assign masked1 = clearing ? '0 : q1;
   assign masked2 = clearing ? '0 : q2;

`ifdef BRAM_OUT_REG_EN
   logic [DATA_WIDTH-1:0] out_r1;
   logic [DATA_WIDTH-1:0] out_r2;

   always_ff @(posedge clk) begin
      if (reset) begin
         out_r1 <= '0;
         out_r2 <= '0;
      end else begin
         out_r1 <= masked1;
         out_r2 <= masked2;
      end
   end

   assign bus.out1 = out_r1;
   assign bus.out2 = out_r2;
`else
   assign bus.out1 = masked1;
   assign bus.out2 = masked2;
`endif

   assign bus.busy      = clearing;
   assign bus.collision = coll_q;
endmodule

// File: tb/tb_bram_dp_ctrl.sv
// Self-checking bench for bram_dp_ctrl using a reference memory model and a timed scoreboard.
// Define BRAM_OUT_REG_EN on both files to exercise the two-cycle read path.
module tb_bram_dp_ctrl;
`ifdef BRAM_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   typedef struct {
      string      tag;
      int         due;
      int         which;
      logic [9:0] exp;
   } sb_t;

   logic       clk;
   logic       reset;
   int         cyc;
   int         checks;
   int         errors;
   logic [9:0] model [32];
   sb_t        sb_q[$];

   bram_dp_ctrl_if #(.ADDR_WIDTH(5), .DATA_WIDTH(10)) bus ();

   bram_dp_ctrl #(.ADDR_WIDTH(5), .DATA_WIDTH(10)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Global time limit so the run always ends
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, observed, expected, cyc);
      end
   endtask

   // Advance one clock and retire every scoreboard entry due on this cycle
   task automatic step();
      sb_t e;
      @(posedge clk);
      cyc++;
      #1;
      for (int i = 0; i < sb_q.size(); ) begin
         if (sb_q[i].due == cyc) begin
            e = sb_q[i];
            sb_q.delete(i);
            case (e.which)
               0:       checkOutput(e.tag, {22'd0, bus.out1}, {22'd0, e.exp});
               1:       checkOutput(e.tag, {22'd0, bus.out2}, {22'd0, e.exp});
               default: checkOutput(e.tag, {31'd0, bus.collision}, {22'd0, e.exp});
            endcase
         end else begin
            i++;
         end
      end
   endtask

   task automatic idle();
      bus.clear_req = 1'b0;
      bus.we1       = 1'b0;
      bus.we2       = 1'b0;
      bus.addr1     = '0;
      bus.addr2     = '0;
      bus.data1     = '0;
      bus.data2     = '0;
   endtask

   // Drive one READY-state cycle and predict both reads and the collision flag
   task automatic applyStimulus(input logic w1, input int a1, input logic [9:0] d1,
                                input logic w2, input int a2, input logic [9:0] d2,
                                input string tag);
      sb_t e;
      bus.clear_req = 1'b0;
      bus.we1       = w1;
      bus.addr1     = 5'(a1);
      bus.data1     = d1;
      bus.we2       = w2;
      bus.addr2     = 5'(a2);
      bus.data2     = d2;
      e.tag = {tag, "_out1"}; e.due = cyc + LAT; e.which = 0; e.exp = model[a1];
      sb_q.push_back(e);
      e.tag = {tag, "_out2"}; e.due = cyc + LAT; e.which = 1; e.exp = model[a2];
      sb_q.push_back(e);
      e.tag = {tag, "_coll"}; e.due = cyc + 1; e.which = 2;
      e.exp = (w1 && w2 && a1 == a2) ? 10'd1 : 10'd0;
      sb_q.push_back(e);
      if (w2 && !(w1 && a1 == a2)) model[a2] = d2;
      if (w1) model[a1] = d1;
      step();
   endtask

   task automatic drain();
      int guard;
      idle();
      guard = 0;
      while (sb_q.size() > 0 && guard < 8) begin
         step();
         guard++;
      end
      checkOutput("sb_drain", sb_q.size(), 0);
   endtask

   // Count CLEAR cycles while hammering ignored inputs; the array model is zeroed afterwards
   task automatic countBusy(input string tag);
      int n;
      n = 0;
      while (bus.busy === 1'b1 && n < 64) begin
         if (n >= LAT - 1) begin
            checkOutput({tag, "_o1_zero"}, {22'd0, bus.out1}, 0);
            checkOutput({tag, "_o2_zero"}, {22'd0, bus.out2}, 0);
         end
         checkOutput({tag, "_coll_zero"}, {31'd0, bus.collision}, 0);
         bus.clear_req = 1'b1;
         bus.we1       = 1'b1;
         bus.we2       = 1'b1;
         bus.addr1     = 5'(n);
         bus.addr2     = 5'(n);
         bus.data1     = 10'h155;
         bus.data2     = 10'h0AA;
         n++;
         step();
      end
      checkOutput({tag, "_busy_len"}, n, 16);
      checkOutput({tag, "_o1_after"}, {22'd0, bus.out1}, 0);
      idle();
      step();
      checkOutput({tag, "_no_requeue"}, {31'd0, bus.busy}, 0);
      checkOutput({tag, "_coll_after"}, {31'd0, bus.collision}, 0);
      for (int i = 0; i < 32; i++) model[i] = '0;
   endtask

   task automatic readAll(input string tag);
      for (int i = 0; i < 32; i++) applyStimulus(1'b0, i, 10'h0, 1'b0, 31 - i, 10'h0, tag);
      drain();
   endtask

   initial begin
      int a1;
      int a2;
      cyc    = 0;
      checks = 0;
      errors = 0;
      for (int i = 0; i < 32; i++) model[i] = 10'h3C3;
      idle();
      reset = 1'b1;
      step();
      step();
      checkOutput("rst_busy", {31'd0, bus.busy}, 1);
      checkOutput("rst_out1", {22'd0, bus.out1}, 0);
      checkOutput("rst_out2", {22'd0, bus.out2}, 0);
      checkOutput("rst_coll", {31'd0, bus.collision}, 0);
      reset = 1'b0;
      countBusy("init");
      readAll("zero_init");

      applyStimulus(1'b1, 3, 10'h2A5, 1'b0, 0, 10'h0, "wr3");
      applyStimulus(1'b0, 0, 10'h0, 1'b0, 3, 10'h0, "rd3");
      drain();

      applyStimulus(1'b1, 7, 10'h111, 1'b1, 7, 10'h222, "coll7");
      applyStimulus(1'b0, 7, 10'h0, 1'b0, 7, 10'h0, "rd7");
      drain();

      applyStimulus(1'b1, 9, 10'h3FF, 1'b0, 9, 10'h0, "rf9");
      applyStimulus(1'b0, 9, 10'h0, 1'b0, 9, 10'h0, "rd9");
      drain();

      for (int i = 0; i < 48; i++) begin
         a1 = $urandom_range(0, 31);
         a2 = ($urandom_range(0, 3) == 0) ? a1 : $urandom_range(0, 31);
         applyStimulus(1'($urandom_range(0, 1)), a1, 10'($urandom_range(0, 1023)),
                       1'($urandom_range(0, 1)), a2, 10'($urandom_range(0, 1023)), "rnd");
      end
      drain();

      for (int i = 0; i < 16; i++) applyStimulus(1'b1, i, 10'(i + 1), 1'b1, i + 16, 10'(i + 17), "fill");
      drain();
      bus.clear_req = 1'b1;
      step();
      bus.clear_req = 1'b0;
      countBusy("req");
      readAll("zero_req");

      for (int i = 0; i < 16; i++) applyStimulus(1'b1, i, 10'(i + 100), 1'b1, i + 16, 10'(i + 200), "fill2");
      drain();
      bus.clear_req = 1'b1;
      step();
      bus.clear_req = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checkOutput("mid_clear_busy", {31'd0, bus.busy}, 1);
         step();
      end
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      countBusy("restart");
      readAll("zero_restart");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
